fpu_host_master: RTL and testbench

Synthesizable host-side initiator for the FPU_Control operand/result interface.
- Accepts an operand pair plus an opcode on a local valid/ready request port.
- Drives the two 32-bit operands over DIN/DIV/DACK.
- Collects the 32-bit result as two 16-bit words over DOUT/DOV/DOA and returns it with exception flags on a valid/ready response port.
- Replaces bench-driven stimulus when FPU_Control is embedded in a larger SoC.

---
 rtl/fpu_host_pkg.sv | 23 ++
 rtl/fpu_host_timeout.sv | 28 ++
 rtl/fpu_host_master.sv | 166 ++++++++++++++++
 tb/tb_fpu_host_master.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_host_pkg.sv
// Shared types and constants for the FPU_Control host-side initiator.
package fpu_host_pkg;

   localparam int WORD_W = 32;
   localparam int HALF_W = 16;
   localparam int EXC_W  = 3;

   localparam logic OPT_MUL = 1'b1;
   localparam logic OPT_ADD = 1'b0;

   typedef enum logic [3:0] {
      IDLE,
      SEND_A,
      SEND_B,
      WAIT_HI,
      ACK_HI,
      WAIT_LO,
      ACK_LO,
      DRAIN,
      RESP
   } state_e;

endpackage

// File: rtl/fpu_host_timeout.sv
// Per-state watchdog: cleared on load, counts while enabled, flags when TIMEOUT is reached.
module fpu_host_timeout #(
   parameter int TIMEOUT = 1024,
   parameter int TO_W    = 11
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic load_i,
   input  logic en_i,
   output logic expired_o
);

   logic [TO_W-1:0] cnt_q;

   // Saturates at TIMEOUT so a held expiry cannot wrap back to zero.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= '0;
      end else if (en_i && !expired_o) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign expired_o = (TIMEOUT != 0) && (cnt_q == TO_W'(TIMEOUT));

endmodule

// File: rtl/fpu_host_master.sv
// Host-side initiator: sends an operand pair to FPU_Control and collects the
// two-half-word result, returning it on a valid/ready response port.
module fpu_host_master
   import fpu_host_pkg::*;
#(
   parameter int   TIMEOUT  = 1024,
   parameter int   TO_W     = 11,
   parameter logic MODE_VAL = 1'b0
) (
   input  logic                CLK,
   input  logic                RSTn,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [WORD_W-1:0]   req_op_a,
   input  logic [WORD_W-1:0]   req_op_b,
   input  logic                req_opt,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [WORD_W-1:0]   rsp_data,
   output logic [EXC_W-1:0]    rsp_exc,
   output logic                rsp_err,
   output logic                CS,
   output logic [WORD_W-1:0]   DIN,
   output logic                DIV,
   input  logic                DACK,
   output logic                OPT,
   output logic                MODE,
   input  logic [HALF_W-1:0]   DOUT,
   input  logic                DOV,
   output logic                DOA,
   input  logic [EXC_W-1:0]    EXC,
   input  logic                ABUSY,
   input  logic                MBUSY
);

   state_e            state_q, state_d;
   logic [WORD_W-1:0] opA_q, opA_d, opB_q, opB_d, din_q, din_d, res_q, res_d;
   logic [EXC_W-1:0]  exc_q, exc_d;
   logic              opt_q, opt_d, div_q, div_d, doa_q, doa_d;
   logic              err_q, err_d, rspValid_q, rspValid_d, cs_q;
   logic              busy, waitState, expired;

   assign busy      = (opt_q == OPT_MUL) ? MBUSY : ABUSY;
   assign waitState = (state_q == SEND_A) || (state_q == SEND_B) || (state_q == WAIT_HI) ||
                      (state_q == WAIT_LO) || (state_q == DRAIN);

   fpu_host_timeout #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) uTimeout (
      .clk_i     (CLK),
      .rst_ni    (RSTn),
      .load_i    (state_d != state_q),
      .en_i      (waitState),
      .expired_o (expired)
   );

   // A word only moves when DIV was already high at the edge, so DACK seen
   // while stalled is ignored; DIV stays up across the A-to-B boundary.
   always_comb begin
      state_d    = state_q;
      opA_d      = opA_q;
      opB_d      = opB_q;
      opt_d      = opt_q;
      div_d      = div_q;
      din_d      = din_q;
      doa_d      = 1'b0;
      res_d      = res_q;
      exc_d      = exc_q;
      err_d      = err_q;
      rspValid_d = rspValid_q;
      unique case (state_q)
         IDLE: if (req_valid) begin
            opA_d   = req_op_a;
            opB_d   = req_op_b;
            opt_d   = req_opt;
            din_d   = req_op_a;
            err_d   = 1'b0;
            state_d = SEND_A;
         end
         SEND_A: if (div_q && DACK) begin
            din_d   = opB_q;
            state_d = SEND_B;
         end else begin
            div_d = !busy;
         end
         SEND_B: if (div_q && DACK) begin
            div_d   = 1'b0;
            state_d = WAIT_HI;
         end else begin
            div_d = !busy;
         end
         WAIT_HI: if (DOV) begin
            res_d   = {DOUT, res_q[HALF_W-1:0]};
            exc_d   = EXC;
            doa_d   = 1'b1;
            state_d = ACK_HI;
         end
         ACK_HI: state_d = WAIT_LO;
         WAIT_LO: if (DOV) begin
            res_d   = {res_q[WORD_W-1:HALF_W], DOUT};
            doa_d   = 1'b1;
            state_d = ACK_LO;
         end
         ACK_LO: state_d = DRAIN;
         DRAIN: if (!DOV) begin
            rspValid_d = 1'b1;
            state_d    = RESP;
         end
         RESP: if (rsp_ready) begin
            rspValid_d = 1'b0;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (waitState && expired) begin
         div_d      = 1'b0;
         doa_d      = 1'b0;
         res_d      = '0;
         err_d      = 1'b1;
         rspValid_d = 1'b1;
         state_d    = RESP;
      end
   end

   // Every FPU-facing output comes straight from a flop.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q    <= IDLE;
         opA_q      <= '0;
         opB_q      <= '0;
         opt_q      <= OPT_ADD;
         div_q      <= 1'b0;
         din_q      <= '0;
         doa_q      <= 1'b0;
         res_q      <= '0;
         exc_q      <= '0;
         err_q      <= 1'b0;
         rspValid_q <= 1'b0;
         cs_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         opA_q      <= opA_d;
         opB_q      <= opB_d;
         opt_q      <= opt_d;
         div_q      <= div_d;
         din_q      <= din_d;
         doa_q      <= doa_d;
         res_q      <= res_d;
         exc_q      <= exc_d;
         err_q      <= err_d;
         rspValid_q <= rspValid_d;
         cs_q       <= 1'b1;
      end
   end

   assign req_ready = (state_q == IDLE);
   assign rsp_valid = rspValid_q;
   assign rsp_data  = res_q;
   assign rsp_exc   = exc_q;
   assign rsp_err   = err_q;
   assign CS        = cs_q;
   assign DIN       = din_q;
   assign DIV       = div_q;
   assign OPT       = opt_q;
   assign MODE      = MODE_VAL;
   assign DOA       = doa_q;

endmodule

// File: tb/tb_fpu_host_master.sv
// Self-checking bench: a behavioural FPU_Control stand-in plus a transaction-level
// scoreboard checked every cycle on the falling clock edge.
module tb_fpu_host_master;

   localparam int TIMEOUT = 16;

   logic        CLK = 1'b0;
   logic        RSTn = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_op_a = '0;
   logic [31:0] req_op_b = '0;
   logic        req_opt = 1'b0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_data;
   logic [2:0]  rsp_exc;
   logic        rsp_err;
   logic        CS, DIV, OPT, MODE, DOA;
   logic [31:0] DIN;
   logic        DACK = 1'b0;
   logic        DOV = 1'b0;
   logic [15:0] DOUT = '0;
   logic [2:0]  EXC = '0;
   logic        ABUSY = 1'b0;
   logic        MBUSY = 1'b0;

   always #5 CLK = ~CLK;

   fpu_host_master #(.TIMEOUT(TIMEOUT), .TO_W(5), .MODE_VAL(1'b0)) dut (
      .CLK(CLK), .RSTn(RSTn),
      .req_valid(req_valid), .req_ready(req_ready), .req_op_a(req_op_a), .req_op_b(req_op_b),
      .req_opt(req_opt),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_exc(rsp_exc),
      .rsp_err(rsp_err),
      .CS(CS), .DIN(DIN), .DIV(DIV), .DACK(DACK), .OPT(OPT), .MODE(MODE),
      .DOUT(DOUT), .DOV(DOV), .DOA(DOA), .EXC(EXC), .ABUSY(ABUSY), .MBUSY(MBUSY)
   );

   int checks = 0;
   int errors = 0;

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   // FPU stand-in: the two documented vectors give true IEEE results, anything else a fixed mix.
   function automatic logic [31:0] fpuResult(input logic [31:0] a, input logic [31:0] b, input logic opt);
      if (a == 32'hC0300000 && b == 32'h40B00000 && opt) return 32'hC1720000;
      if (a == 32'h40300000 && b == 32'h40B00000 && !opt) return 32'h41040000;
      return {a[15:0] ^ b[31:16], a[31:16] + b[15:0]} ^ {32{opt}};
   endfunction

   function automatic logic [2:0] fpuExc(input logic [31:0] a, input logic [31:0] b, input logic opt);
      if (fpuResult(a, b, opt) == 32'hC1720000 || fpuResult(a, b, opt) == 32'h41040000) return 3'b000;
      return a[2:0] ^ b[2:0] ^ {2'b00, opt};
   endfunction

   typedef enum int {PH_NONE, PH_DELAY, PH_HI, PH_LO, PH_DRAIN} phase_e;

   // Scoreboard / slave state
   logic [31:0] curA, curB, curRes;
   logic [2:0]  curExc;
   logic        curOpt, curStuck;
   bit          outstanding = 0;
   int          words = 0;
   int          acceptCount = 0, rspCount = 0;
   logic        lastOpt = 1'b0;
   phase_e      phase = PH_NONE;
   int          phaseCnt = 0, doaCount = 0, latency = 0;
   bit          prevDoa = 0, prevStall = 0, sawEdge = 0, firstRsp = 1;
   bit          stuckDack = 0, forceMbusy = 0;
   logic [31:0] lastData;
   logic [2:0]  lastExc;
   logic        lastErr;
   int          lastDoaCount;

   always @(negedge CLK) begin
      bit transfer;
      if (!RSTn) begin
         outstanding = 0; words = 0; phase = PH_NONE; lastOpt = 1'b0; sawEdge = 0;
         prevDoa = 0; prevStall = 0; doaCount = 0;
         DACK = 1'b0; DOV = 1'b0; DOUT = '0; EXC = '0; ABUSY = 1'b0; MBUSY = 1'b0;
      end else begin
         checkOutput("CS", CS, 32'(sawEdge));
         checkOutput("MODE", MODE, 0);
         checkOutput("req_ready", req_ready, 32'(!outstanding));
         checkOutput("OPT", OPT, lastOpt);
         if (!outstanding || words == 2) checkOutput("DIV idle", DIV, 0);
         else if (DIV) checkOutput("DIN", DIN, (words == 0) ? curA : curB);
         if (prevStall) checkOutput("DIV stall", DIV, 0);
         if (!outstanding) checkOutput("DOA idle", DOA, 0);
         if (prevDoa) checkOutput("DOA pulse", DOA, 0);
         if (!outstanding) checkOutput("rsp_valid idle", rsp_valid, 0);
         else if (rsp_valid) begin
            checkOutput("rsp_err", rsp_err, curStuck);
            checkOutput("rsp_data", rsp_data, curStuck ? 32'h0 : curRes);
            checkOutput("DIV at resp", DIV, 0);
            if (!curStuck) begin
               checkOutput("rsp_exc", rsp_exc, curExc);
               checkOutput("DOA count", doaCount, 2);
               checkOutput("DOV drained", 32'(phase == PH_NONE), 1);
            end else if (firstRsp) begin
               checkOutput("timeout latency", 32'(latency >= TIMEOUT && latency <= TIMEOUT + 4), 1);
            end
            firstRsp = 0;
         end
         if (outstanding) latency++;

         // Drive the FPU side for the coming rising edge
         DACK  = stuckDack ? 1'b0 : ($urandom_range(9) < 7);
         ABUSY = ($urandom_range(9) < 2);
         MBUSY = forceMbusy || ($urandom_range(9) < 2);
         EXC   = 3'($urandom);
         if (phase == PH_DELAY) begin
            if (phaseCnt == 0) phase = PH_HI; else phaseCnt--;
         end
         if (phase == PH_DRAIN) begin
            if (phaseCnt == 0) phase = PH_NONE; else phaseCnt--;
         end
         case (phase)
            PH_NONE:  begin DOV = outstanding && words < 2 && ($urandom_range(3) == 0); DOUT = 16'($urandom); end
            PH_DELAY: begin DOV = 1'b0; DOUT = 16'($urandom); end
            PH_HI:    begin DOV = 1'b1; DOUT = curRes[31:16]; EXC = curExc; end
            PH_LO:    begin DOV = 1'b1; DOUT = curRes[15:0]; end
            default:  begin DOV = 1'b1; DOUT = 16'($urandom); end
         endcase

         // Predict what the coming rising edge does
         transfer  = DIV && DACK && outstanding && words < 2;
         prevStall = outstanding && words < 2 && !rsp_valid && !transfer && (curOpt ? MBUSY : ABUSY);
         if (transfer) begin
            words++;
            if (words == 2) begin phase = PH_DELAY; phaseCnt = $urandom_range(4); end
         end
         if (DOA) begin
            doaCount++;
            if (phase == PH_HI) phase = PH_LO;
            else if (phase == PH_LO) begin phase = PH_DRAIN; phaseCnt = $urandom_range(3); end
         end
         prevDoa = DOA;
         if (rsp_valid && rsp_ready && outstanding) begin
            lastData = rsp_data; lastExc = rsp_exc; lastErr = rsp_err; lastDoaCount = doaCount;
            outstanding = 0;
            rspCount++;
         end
         if (req_valid && req_ready) begin
            curA = req_op_a; curB = req_op_b; curOpt = req_opt; curStuck = stuckDack;
            curRes = fpuResult(req_op_a, req_op_b, req_opt);
            curExc = fpuExc(req_op_a, req_op_b, req_opt);
            outstanding = 1; words = 0; doaCount = 0; latency = 0; firstRsp = 1;
            lastOpt = req_opt; phase = PH_NONE;
            acceptCount++;
         end
         sawEdge = 1;
      end
   end

   task automatic tick();
      @(posedge CLK);
      #2;
   endtask

   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic opt);
      int n = 0;
      int c0 = acceptCount;
      req_op_a = a; req_op_b = b; req_opt = opt; req_valid = 1'b1;
      while (acceptCount == c0 && n < 100) begin tick(); n++; end
      req_valid = 1'b0; req_op_a = $urandom; req_op_b = $urandom; req_opt = 1'($urandom);
      checkOutput("request accepted", 32'(acceptCount != c0), 1);
   endtask

   task automatic waitResponse(input int hold);
      int n = 0;
      int held = 0;
      int c0 = rspCount;
      rsp_ready = 1'b0;
      while (rspCount == c0 && n < 300) begin
         tick(); n++;
         if (rsp_valid) begin
            if (held >= hold) rsp_ready = 1'b1; else held++;
         end
      end
      rsp_ready = 1'b0;
      checkOutput("response received", 32'(rspCount != c0), 1);
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, " CS"}, CS, 0);
      checkOutput({tag, " DIV"}, DIV, 0);
      checkOutput({tag, " DOA"}, DOA, 0);
      checkOutput({tag, " DIN"}, DIN, 0);
      checkOutput({tag, " OPT"}, OPT, 0);
      checkOutput({tag, " rsp_valid"}, rsp_valid, 0);
      checkOutput({tag, " rsp_data"}, rsp_data, 0);
      checkOutput({tag, " rsp_exc"}, rsp_exc, 0);
      checkOutput({tag, " rsp_err"}, rsp_err, 0);
      checkOutput({tag, " req_ready"}, req_ready, 1);
   endtask

   initial begin
      int n;
      int c0;
      repeat (3) @(posedge CLK);
      #2;
      checkResetValues("reset");
      RSTn = 1'b1;
      tick();

      $display("[TB] multiply");
      applyStimulus(32'hC0300000, 32'h40B00000, 1'b1);
      waitResponse(0);
      checkOutput("mul data", lastData, 32'hC1720000);
      checkOutput("mul exc", lastExc, 0);
      checkOutput("mul err", lastErr, 0);
      checkOutput("mul DOA pulses", lastDoaCount, 2);

      $display("[TB] add");
      applyStimulus(32'h40300000, 32'h40B00000, 1'b0);
      waitResponse(0);
      checkOutput("add data", lastData, 32'h41040000);
      checkOutput("add err", lastErr, 0);

      $display("[TB] busy stall");
      forceMbusy = 1;
      applyStimulus(32'hC0300000, 32'h40B00000, 1'b1);
      for (int i = 0; i < 5; i++) begin
         tick();
         checkOutput("stall DIV", DIV, 0);
      end
      forceMbusy = 0;
      waitResponse(0);
      checkOutput("stall data", lastData, 32'hC1720000);

      $display("[TB] back-pressure");
      applyStimulus($urandom, $urandom, 1'b0);
      c0 = acceptCount;
      req_op_a = 32'h40300000; req_op_b = 32'h40B00000; req_opt = 1'b0; req_valid = 1'b1;
      waitResponse(10);
      checkOutput("no accept before handshake", acceptCount, c0);
      n = 0;
      while (acceptCount == c0 && n < 20) begin tick(); n++; end
      req_valid = 1'b0;
      checkOutput("accept after handshake", 32'(acceptCount == c0 + 1), 1);
      waitResponse(0);
      checkOutput("queued add data", lastData, 32'h41040000);

      $display("[TB] timeout");
      stuckDack = 1;
      applyStimulus(32'h12345678, 32'h9ABCDEF0, 1'b1);
      waitResponse(0);
      stuckDack = 0;
      checkOutput("timeout err", lastErr, 1);
      checkOutput("timeout data", lastData, 0);
      applyStimulus(32'h40300000, 32'h40B00000, 1'b0);
      waitResponse(0);
      checkOutput("err cleared", lastErr, 0);
      checkOutput("post-timeout data", lastData, 32'h41040000);

      $display("[TB] reset mid-operation");
      applyStimulus(32'hC0300000, 32'h40B00000, 1'b1);
      n = 0;
      while (phase != PH_LO && n < 100) begin tick(); n++; end
      checkOutput("reached WAIT_LO", 32'(phase == PH_LO), 1);
      c0 = rspCount;
      RSTn = 1'b0;
      #1;
      checkResetValues("async reset");
      tick(); tick();
      RSTn = 1'b1;
      repeat (20) tick();
      checkOutput("CS after release", CS, 1);
      checkOutput("req_ready after release", req_ready, 1);
      checkOutput("no response after reset", rspCount, c0);

      $display("[TB] random traffic");
      for (int i = 0; i < 30; i++) begin
         applyStimulus($urandom, $urandom, 1'($urandom));
         waitResponse($urandom_range(3));
         repeat ($urandom_range(2)) tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
